mb_seq_multiplier: RTL and testbench

Sequential radix-4 modified-Booth multiplier core. It is the iterative stage that replaces the fully parallel partial-product sum. It accepts two unsigned operands over a valid/ready handshake and recodes the multiplier one Booth digit per cycle. Each cycle it forms one signed partial product of the multiplicand and accumulates it at the digit's weight, then returns the full 64-bit product over a second valid/ready handshake.

---
 rtl/mb_pkg.sv | 43 ++++
 rtl/mb_digit_pp.sv | 30 +++
 rtl/mb_seq_multiplier.sv | 117 +++++++++++
 tb/tb_mb_seq_multiplier.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared definitions for the sequential radix-4 modified-Booth multiplier.
//   state_e      : controller states (IDLE / RUN / DONE)
//   WIDTH_DEF    : default operand width
//   booth_sel_t  : one-hot magnitude select (one, two) plus negate flag
//   booth_decode : maps a recoding triple q[2:0] to a booth_sel_t
package mb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } booth_sel_t;

  // Radix-4 Booth recoding. 000 and 111 are both digit 0; neg is left clear
  // for them so a zero digit never produces a negated (still zero) term.
  function automatic booth_sel_t booth_decode(input logic [2:0] t);
    booth_sel_t s;
    s = '0;
    case (t)
      3'b001, 3'b010: s.one = 1'b1;
      3'b011:         s.two = 1'b1;
      3'b100: begin
        s.two = 1'b1;
        s.neg = 1'b1;
      end
      3'b101, 3'b110: begin
        s.one = 1'b1;
        s.neg = 1'b1;
      end
      default:        s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mb_digit_pp.sv
// Combinational Booth partial-product generator.
//   triple : current recoding window q[2:0]
//   b      : unsigned multiplicand
//   pp     : signed digit*b, digit in {-2,-1,0,+1,+2}, WIDTH+3 bits wide so
//            that +/-2*b of an unsigned WIDTH-bit value fits without overflow
module mb_digit_pp
  import mb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]              triple,
  input  logic [WIDTH-1:0]        b,
  output logic signed [WIDTH+2:0] pp
);

  booth_sel_t       sel;
  logic [WIDTH+2:0] mag;

  always_comb begin
    sel = booth_decode(triple);
    mag = '0;
    if (sel.one) begin
      mag = {3'b000, b};
    end else if (sel.two) begin
      mag = {2'b00, b, 1'b0};
    end
    pp = sel.neg ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/mb_seq_multiplier.sv
// Sequential radix-4 modified-Booth multiplier, one Booth digit per cycle.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a = multiplier, b = multiplicand)
//   out_valid / out_ready: product handshake, product = a*b (2*WIDTH bits)
//   busy                 : high whenever the controller is not idle
// Latency is DIGITS cycles from acceptance to out_valid; the product is held
// stable in DONE until the consumer takes it.
module mb_seq_multiplier
  import mb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  // Unsigned operands need one extra digit so the top digit sees the
  // zero-extended sign bits and is never negative.
  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int PW     = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [WIDTH+2:0]    q_q, q_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic                in_ready_q;

  logic signed [WIDTH+2:0] pp;
  logic [PW-1:0]           pp_ext;
  logic [PW-1:0]           pp_sh;
  logic                    accept;

  mb_digit_pp #(.WIDTH(WIDTH)) u_digit_pp (
    .triple (q_q[2:0]),
    .b      (b_q),
    .pp     (pp)
  );

  // Sign-extend and weight the digit; bits shifted past 2*WIDTH are dropped,
  // which is exact because the true product always fits in 2*WIDTH bits.
  assign pp_ext = {{(PW - WIDTH - 3){pp[WIDTH+2]}}, pp};
  assign pp_sh  = pp_ext << {cnt_q, 1'b0};

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          q_d     = {2'b00, a, 1'b0};
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + pp_sh;
        q_d   = q_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready is registered so it stays low through the reset edge and no
  // input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      in_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Operand registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    q_q <= q_d;
    b_q <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign product   = acc_q;

endmodule

// File: tb/tb_mb_seq_multiplier.sv
module tb_mb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  mb_seq_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation with out_ready high, check latency and product.
  task automatic run_op(input string name, input logic [31:0] va,
                        input logic [31:0] vb, input logic [63:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    a = va;
    b = vb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd17);
    chk({name, " product"}, product, exp);
    step();
    chk({name, " idle after hs"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    logic [63:0] prods[$];
    int          acc_t[$];
    logic        acc_now;
    logic        hs;
    logic [63:0] p;
    logic        saw_ready;
    int          n;

    vecs[0] = '{32'h0e5482fc, 32'h2fc68201, 64'h02aca0b08bc07afc};
    vecs[1] = '{32'hffffffff, 32'hffffffff, 64'hfffffffe00000001};
    vecs[2] = '{32'h00000000, 32'h12345678, 64'h0000000000000000};
    vecs[3] = '{32'h00000003, 32'h00000005, 64'h000000000000000f};
    vecs[4] = '{32'hffffffff, 32'h00000001, 64'h00000000ffffffff};
    vecs[5] = '{32'h00000002, 32'hffffffff, 64'h00000001fffffffe};
    vecs[6] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[7] = '{32'h00010000, 32'h00001234, 64'h0000000012340000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset product", product, 64'd0);
    rst_n = 1'b1;
    step();
    chk("in_ready after release", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    a = 32'h0;
    b = 32'h12345678;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      acc_now = in_valid && in_ready;
      hs = out_valid && out_ready;
      p = product;
      step();
      if (hs) prods.push_back(p);
      if (acc_now) begin
        acc_t.push_back(i);
        if (acc_t.size() == 1) begin
          a = 32'h1;
          b = 32'h80000000;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b accept count", 64'(acc_t.size()), 64'd2);
    chk("b2b product count", 64'(prods.size()), 64'd2);
    if (acc_t.size() == 2) chk("b2b interval", 64'(acc_t[1] - acc_t[0]), 64'd19);
    if (prods.size() == 2) begin
      chk("b2b product0", prods[0], 64'h0);
      chk("b2b product1", prods[1], 64'h0000000080000000);
    end

    // Output backpressure, with a competing operand pending during DONE.
    out_ready = 1'b0;
    a = 32'h00010000;
    b = 32'h00001234;
    in_valid = 1'b1;
    step();
    a = 32'h11111111;
    b = 32'h22222222;
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk("bp latency", 64'(n), 64'd17);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold%0d", k), {busy, in_ready, out_valid, product[60:0]},
          {1'b1, 1'b0, 1'b1, 61'h12340000});
      step();
    end
    out_ready = 1'b1;
    chk("bp 6th valid", 64'(out_valid), 64'd1);
    step();
    chk("bp after hs", {61'd0, busy, in_ready, out_valid}, 64'b010);
    in_valid = 1'b0;

    // Reset mid-RUN aborts the operation.
    run_op("pre-abort", 32'h5, 32'h6, 64'd30);
    a = 32'hffffffff;
    b = 32'hffffffff;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort product", product, 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    step();
    chk("abort no product", 64'(out_valid), 64'd0);
    run_op("post-abort", 32'h3, 32'h5, 64'hf);

    // Operand change during RUN.
    out_ready = 1'b1;
    a = 32'd7;
    b = 32'd9;
    in_valid = 1'b1;
    step();
    a = 32'hdeadbeef;
    b = 32'hdeadbeef;
    saw_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      if (in_ready) saw_ready = 1'b1;
      step();
      n++;
    end
    chk("chg in_ready low", 64'(saw_ready), 64'd0);
    chk("chg latency", 64'(n), 64'd17);
    chk("chg product", product, 64'd63);
    step();
    chk("chg no same-cycle accept", {62'd0, busy, in_ready}, 64'b01);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
